// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared state encoding and frame constants for the UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Per-bit down-counter; flags the last cycle of each serial bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reloads on every bit boundary so consecutive bits need no extra cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end     = (cnt_q == '0);
    assign bit_pre_end = (cnt_q == ONE);

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// ============================================================================
// Module   : uart_tx_drain
// Brief    : Pops bytes from an upstream FIFO and serialises them as UART frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_drain
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_enb,
    output logic        fifo_rd_reg,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] byte_count
);

    localparam logic                 ODD_BIT  = (PARITY_ODD != 0);
    localparam logic                 HAS_PAR  = (PARITY_EN != 0);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   parity_q, parity_d;
    logic                   armed_q, armed_d;
    logic                   tx_q, tx_d;
    logic                   fifo_rd_enb_q, fifo_rd_enb_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            byte_count_q, byte_count_d;

    logic                   baud_restart;
    logic                   bit_end;
    logic                   bit_pre_end;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (baud_restart),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        parity_d     = parity_q;
        armed_d      = 1'b1;
        baud_restart = 1'b0;

        // Raised one cycle early so the registered pulse lands on the last STOP cycle.
        frame_done_d = (state_q == STOP) && bit_pre_end;
        byte_count_d = frame_done_d ? (byte_count_q + 16'd1) : byte_count_q;

        case (state_q)
            IDLE: begin
                // armed_q keeps the first cycle out of reset free of pops.
                if (armed_q && tx_enable && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d      = fifo_data;
                parity_d     = (^fifo_data) ^ ODD_BIT;
                baud_restart = 1'b1;
                state_d      = START;
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = (tx_enable && !fifo_empty) ? POP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d        = (state_d != IDLE);
        fifo_rd_enb_d = (state_d == POP);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            parity_q      <= 1'b0;
            armed_q       <= 1'b0;
            tx_q          <= 1'b1;
            fifo_rd_enb_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            parity_q      <= parity_d;
            armed_q       <= armed_d;
            tx_q          <= tx_d;
            fifo_rd_enb_q <= fifo_rd_enb_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign tx          = tx_q;
    assign fifo_rd_enb = fifo_rd_enb_q;
    assign fifo_rd_reg = 1'b0;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign byte_count  = byte_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// ============================================================================
// Module   : tb_uart_tx_drain
// Brief    : Self-checking bench for uart_tx_drain (no parity, even, odd parity).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_drain;

    localparam int CLKS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i [3];
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        tx_o [3];
    logic        rd_o [3];
    logic        rr_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [15:0] cnt_o [3];

    int          sel;
    int          vectors;
    int          errors;
    logic [15:0] exp_count [3];
    logic [7:0]  fq [$];
    logic [7:0]  pop_byte;

    always #5 clk = ~clk;

    uart_tx_drain #(.CLKS_PER_BIT(CLKS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en_i[0]), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_enb(rd_o[0]), .fifo_rd_reg(rr_o[0]),
        .tx(tx_o[0]), .busy(busy_o[0]), .frame_done(done_o[0]), .byte_count(cnt_o[0]));

    uart_tx_drain #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en_i[1]), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_enb(rd_o[1]), .fifo_rd_reg(rr_o[1]),
        .tx(tx_o[1]), .busy(busy_o[1]), .frame_done(done_o[1]), .byte_count(cnt_o[1]));

    uart_tx_drain #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en_i[2]), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_enb(rd_o[2]), .fifo_rd_reg(rr_o[2]),
        .tx(tx_o[2]), .busy(busy_o[2]), .frame_done(done_o[2]), .byte_count(cnt_o[2]));

    // Upstream FIFO model: registered read data one cycle after the pop.
    always @(posedge clk) begin
        if (rst_n && rd_o[sel]) begin
            vectors++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL underflow: fifo_rd_enb=1 with fifo empty, want no pop");
            end else begin
                pop_byte = fq.pop_front();
                fifo_data  <= pop_byte;
                fifo_empty <= (fq.size() == 0);
            end
        end
    end

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty <= 1'b0;
    endtask

    task automatic wait_pop(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (rd_o[sel] === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL wait_pop: no fifo_rd_enb within %0d cycles, want a pop", limit);
        end else if (tx_o[sel] !== 1'b1 || done_o[sel] !== 1'b0) begin
            errors++;
            $display("FAIL pop_cycle: tx=%b done=%b, want 1 0", tx_o[sel], done_o[sel]);
        end
    endtask

    // Expected frame built from the line format: start, 8 data LSB first, optional parity, stop.
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic exp_bits [11];
        logic par;
        logic exp_done;
        int   nb;
        int   cyc;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        nb = 9;
        if (sel != 0) begin
            par = ^b;
            if (sel == 2) par = ~par;
            exp_bits[9] = par;
            nb = 10;
        end
        exp_bits[nb] = 1'b1;
        nb++;

        @(negedge clk);
        vectors++;
        if (tx_o[sel] !== 1'b1 || rd_o[sel] !== 1'b0 || busy_o[sel] !== 1'b1) begin
            errors++;
            $display("FAIL load_cycle: tx=%b rd=%b busy=%b, want 1 0 1",
                     tx_o[sel], rd_o[sel], busy_o[sel]);
        end

        cyc = 0;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < CLKS; k++) begin
                @(negedge clk);
                if (cyc == drop_at) en_i[sel] = 1'b0;
                exp_done = (i == nb - 1) && (k == CLKS - 1);
                vectors++;
                if (tx_o[sel] !== exp_bits[i] || done_o[sel] !== exp_done ||
                    rd_o[sel] !== 1'b0 || busy_o[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame[%0d] byte %h bit %0d cyc %0d: tx=%b done=%b rd=%b busy=%b, want %b %b 0 1",
                             sel, b, i, k, tx_o[sel], done_o[sel], rd_o[sel], busy_o[sel],
                             exp_bits[i], exp_done);
                end
                cyc++;
            end
        end

        exp_count[sel] = exp_count[sel] + 16'd1;
        vectors++;
        if (cnt_o[sel] !== exp_count[sel]) begin
            errors++;
            $display("FAIL byte_count[%0d]: got %h, want %h", sel, cnt_o[sel], exp_count[sel]);
        end
    endtask

    task automatic check_idle(input int tag);
        @(negedge clk);
        vectors++;
        if (busy_o[sel] !== 1'b0 || tx_o[sel] !== 1'b1 || rd_o[sel] !== 1'b0 || done_o[sel] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_%0d: busy=%b tx=%b rd=%b done=%b, want 0 1 0 0",
                     tag, busy_o[sel], tx_o[sel], rd_o[sel], done_o[sel]);
        end
    endtask

    task automatic check_reset_state(input int tag);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (tx_o[k] !== 1'b1 || rd_o[k] !== 1'b0 || busy_o[k] !== 1'b0 ||
                done_o[k] !== 1'b0 || cnt_o[k] !== 16'h0000 || rr_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state_%0d[%0d]: tx=%b rd=%b busy=%b done=%b count=%h rd_reg=%b, want 1 0 0 0 0000 0",
                         tag, k, tx_o[k], rd_o[k], busy_o[k], done_o[k], cnt_o[k], rr_o[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state(1);
        for (int k = 0; k < 3; k++) exp_count[k] = 16'h0000;
    endtask

    task automatic test_single();
        bit got;
        sel = 0;
        push(8'hA5);
        en_i[0] = 1'b1;
        wait_pop(10, got);
        check_frame(8'hA5, -1);
        en_i[0] = 1'b0;
        check_idle(1);
    endtask

    task automatic test_back_to_back();
        bit got;
        sel = 0;
        push(8'h00);
        push(8'hFF);
        en_i[0] = 1'b1;
        wait_pop(10, got);
        check_frame(8'h00, -1);
        wait_pop(1, got);
        check_frame(8'hFF, -1);
        en_i[0] = 1'b0;
        check_idle(2);
    endtask

    task automatic test_parity();
        bit got;
        for (int s = 1; s < 3; s++) begin
            sel = s;
            push(8'h07);
            en_i[s] = 1'b1;
            wait_pop(10, got);
            check_frame(8'h07, -1);
            en_i[s] = 1'b0;
            check_idle(3);
        end
    endtask

    task automatic test_random();
        bit         got;
        logic [7:0] bs [6];
        int         n;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            n = 2 + int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                bs[i] = 8'($urandom);
                push(bs[i]);
            end
            en_i[s] = 1'b1;
            for (int i = 0; i < n; i++) begin
                wait_pop((i == 0) ? 10 : 1, got);
                check_frame(bs[i], -1);
            end
            en_i[s] = 1'b0;
            check_idle(4);
        end
    endtask

    task automatic test_empty_idle();
        sel = 0;
        en_i[0] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            vectors++;
            if (rd_o[0] !== 1'b0 || tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle: rd=%b tx=%b busy=%b, want 0 1 0", rd_o[0], tx_o[0], busy_o[0]);
            end
        end
        en_i[0] = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit         got;
        bit         saw_rd;
        logic [7:0] bs [3];
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            bs[i] = 8'($urandom);
            push(bs[i]);
        end
        en_i[0] = 1'b1;
        wait_pop(10, got);
        check_frame(bs[0], 10);
        saw_rd = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (rd_o[0] !== 1'b0) saw_rd = 1'b1;
        end
        vectors++;
        if (saw_rd || busy_o[0] !== 1'b0 || fq.size() != 2) begin
            errors++;
            $display("FAIL enable_drop: extra_pop=%b busy=%b queued=%0d, want 0 0 2",
                     saw_rd, busy_o[0], fq.size());
        end
        en_i[0] = 1'b1;
        wait_pop(10, got);
        check_frame(bs[1], -1);
        wait_pop(1, got);
        check_frame(bs[2], -1);
        en_i[0] = 1'b0;
        check_idle(5);
    endtask

    task automatic test_reset_mid();
        bit         got;
        logic [7:0] b0;
        logic [7:0] b1;
        sel = 0;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(b0);
        push(b1);
        en_i[0] = 1'b1;
        wait_pop(10, got);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state(2);
        repeat (2) @(negedge clk);
        check_reset_state(3);
        for (int k = 0; k < 3; k++) exp_count[k] = 16'h0000;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rd_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_after_reset: rd=%b, want 0", rd_o[0]);
        end
        // The byte popped before reset is gone; the next frame must carry b1.
        wait_pop(10, got);
        check_frame(b1, -1);
        en_i[0] = 1'b0;
        check_idle(6);
    endtask

    task automatic test_wrap();
        bit         got;
        logic [7:0] b;
        sel = 0;
        // Stands in for 65535 completed frames.
        @(negedge clk);
        force dut0.byte_count_q = 16'hFFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        release dut0.byte_count_q;
        exp_count[0] = 16'hFFFF;
        b = 8'($urandom);
        push(b);
        en_i[0] = 1'b1;
        wait_pop(10, got);
        check_frame(b, -1);
        en_i[0] = 1'b0;
        vectors++;
        if (cnt_o[0] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: byte_count=%h, want 0000", cnt_o[0]);
        end
        check_idle(7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        errors  = 0;
        sel     = 0;
        for (int k = 0; k < 3; k++) begin
            en_i[k]      = 1'b0;
            exp_count[k] = 16'h0000;
        end
        fifo_empty <= 1'b1;
        fifo_data  <= 8'h00;
        rst_n = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_random();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid();
        test_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
